// File: rtl/multi_alarm_unit.sv
// -----------------------------------------------------------------------------
// multi_alarm_unit
//
// Purpose:
//   Bank of N_ALARMS alarm channels, each holding an editable HH:MM time and an
//   armed bit. A shared three-state FSM (IDLE / RINGING / SNOOZED) rings when an
//   armed channel matches the current time on a minute tick. A ring ends on
//   stop, on disarming the ringing channel, or after RING_TIMEOUT minutes.
//
// Configuration:
//   MULTI_ALARM_SNOOZE_EN  defined   -> snooze input moves RINGING to SNOOZED,
//                                       which re-rings after SNOOZE_MIN ticks.
//                          undefined -> snooze input is ignored and SNOOZED is
//                                       never entered.
//
// Ports:
//   clk_out        in   clock, all state changes on the rising edge
//   reset          in   synchronous active-low reset
//   ch_sel         in   channel selected for edit and display
//   en_minutes     in   step selected channel minutes each clock while high
//   en_hours       in   step selected channel hours each clock while high
//   up_down        in   1 = increment, 0 = decrement
//   arm_toggle     in   pulse, toggle armed bit of the selected channel
//   cur_minutes    in   current time minutes (0..59)
//   cur_hours      in   current time hours (0..23)
//   minute_tick    in   pulse when the current time changes minute
//   stop           in   pulse, silence the alarm
//   snooze         in   pulse, snooze the alarm
//   minutes_units  out  selected channel minutes mod 10
//   minutes_tens   out  selected channel minutes / 10
//   hours_units    out  selected channel hours mod 10
//   hours_tens     out  selected channel hours / 10
//   armed          out  armed bit per channel
//   ring           out  high while ringing
//   ring_ch        out  channel that triggered the most recent ring
// -----------------------------------------------------------------------------
module multi_alarm_unit #(
  parameter int N_ALARMS     = 4,
  parameter int SNOOZE_MIN   = 5,
  parameter int RING_TIMEOUT = 10,
  localparam int CW          = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk_out,
  input  logic                reset,
  input  logic [CW-1:0]       ch_sel,
  input  logic                en_minutes,
  input  logic                en_hours,
  input  logic                up_down,
  input  logic                arm_toggle,
  input  logic [5:0]          cur_minutes,
  input  logic [4:0]          cur_hours,
  input  logic                minute_tick,
  input  logic                stop,
  input  logic                snooze,
  output logic [3:0]          minutes_units,
  output logic [2:0]          minutes_tens,
  output logic [3:0]          hours_units,
  output logic [1:0]          hours_tens,
  output logic [N_ALARMS-1:0] armed,
  output logic                ring,
  output logic [CW-1:0]       ring_ch
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RINGING,
    ST_SNOOZED
  } state_e;

`ifdef MULTI_ALARM_SNOOZE_EN
  localparam bit SnoozeEn = 1'b1;
`else
  localparam bit SnoozeEn = 1'b0;
`endif

  // Per-channel time and arm state
  logic [5:0]          min_q [N_ALARMS];
  logic [5:0]          min_d [N_ALARMS];
  logic [4:0]          hr_q  [N_ALARMS];
  logic [4:0]          hr_d  [N_ALARMS];
  logic [N_ALARMS-1:0] armed_q, armed_d;

  // Ring FSM
  state_e              state_q, state_d;
  logic                ring_q;
  logic [CW-1:0]       ring_ch_q, ring_ch_d;
  logic [5:0]          ring_cnt_q, ring_cnt_d;
  logic [5:0]          snz_cnt_q, snz_cnt_d;

  logic                sel_valid;
  logic                match_any;
  logic [CW-1:0]       match_idx;
  logic                disarm_ring;
  logic                snooze_eff;
  logic [5:0]          sel_min;
  logic [4:0]          sel_hr;

  // Wrapping single steps; minutes never carry into hours.
  function automatic logic [5:0] step_min(input logic [5:0] v, input logic up);
    if (up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  function automatic logic [4:0] step_hr(input logic [4:0] v, input logic up);
    if (up) return (v == 5'd23) ? 5'd0 : v + 5'd1;
    else    return (v == 5'd0) ? 5'd23 : v - 5'd1;
  endfunction

  assign sel_valid  = (int'(ch_sel) < N_ALARMS);
  assign snooze_eff = SnoozeEn && snooze;

  // Toggling the ringing channel always disarms it, since only an armed
  // channel can have started the ring.
  assign disarm_ring = arm_toggle && sel_valid && (ch_sel == ring_ch_q) &&
                       armed_q[ring_ch_q];

  // Lowest-index armed channel matching the current time.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (armed_q[i] && (min_q[i] == cur_minutes) && (hr_q[i] == cur_hours)) begin
        match_any = 1'b1;
        match_idx = CW'(i);
      end
    end
  end

  // Channel edits
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    min_d   = min_q;
    hr_d    = hr_q;
    armed_d = armed_q;
    if (sel_valid) begin
      if (en_minutes) min_d[ch_sel] = step_min(min_q[ch_sel], up_down);
      if (en_hours)   hr_d[ch_sel]  = step_hr(hr_q[ch_sel], up_down);
      if (arm_toggle) armed_d[ch_sel] = ~armed_q[ch_sel];
    end
  end

  // Ring FSM next state; stop, snooze and disarm take priority over the tick.
  always_comb begin
    state_d    = state_q;
    ring_ch_d  = ring_ch_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (minute_tick && match_any && !stop && !snooze_eff) begin
          state_d    = ST_RINGING;
          ring_ch_d  = match_idx;
          ring_cnt_d = '0;
        end
      end
      ST_RINGING: begin
        if (disarm_ring || stop) begin
          state_d = ST_IDLE;
        end else if (snooze_eff) begin
          state_d   = ST_SNOOZED;
          snz_cnt_d = 6'(SNOOZE_MIN);
        end else if (minute_tick) begin
          ring_cnt_d = ring_cnt_q + 6'd1;
          if (ring_cnt_d == 6'(RING_TIMEOUT)) state_d = ST_IDLE;
        end
      end
      ST_SNOOZED: begin
        if (disarm_ring || stop) begin
          state_d = ST_IDLE;
        end else if (snooze_eff) begin
          snz_cnt_d = 6'(SNOOZE_MIN);
        end else if (minute_tick) begin
          snz_cnt_d = snz_cnt_q - 6'd1;
          if (snz_cnt_q == 6'd1) begin
            state_d    = ST_RINGING;
            ring_cnt_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_out) begin
    if (!reset) begin
      // NOTE: the channel time array is flops and must come up 00:00, so it is reset explicitly.
      for (int i = 0; i < N_ALARMS; i++) begin
        min_q[i] <= '0;
        hr_q[i]  <= '0;
      end
      armed_q    <= '0;
      state_q    <= ST_IDLE;
      ring_q     <= 1'b0;
      ring_ch_q  <= '0;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
    end else begin
      min_q      <= min_d;
      hr_q       <= hr_d;
      armed_q    <= armed_d;
      state_q    <= state_d;
      ring_q     <= (state_d == ST_RINGING);
      ring_ch_q  <= ring_ch_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
    end
  end

  // Display of the selected channel, zero for an out-of-range selection.
  assign sel_min = sel_valid ? min_q[ch_sel] : 6'd0;
  assign sel_hr  = sel_valid ? hr_q[ch_sel]  : 5'd0;

  assign minutes_units = 4'(sel_min % 6'd10);
  assign minutes_tens  = 3'(sel_min / 6'd10);
  assign hours_units   = 4'(sel_hr % 5'd10);
  assign hours_tens    = 2'(sel_hr / 5'd10);

  assign armed   = armed_q;
  assign ring    = ring_q;
  assign ring_ch = ring_ch_q;

endmodule

// File: tb/tb_multi_alarm_unit.sv
module tb_multi_alarm_unit;

  localparam int N   = 4;
  localparam int SNZ = 5;
  localparam int RTO = 10;
  localparam int CW  = 2;

`ifdef MULTI_ALARM_SNOOZE_EN
  localparam bit SNOOZE_ON = 1'b1;
`else
  localparam bit SNOOZE_ON = 1'b0;
`endif

  localparam int MODE_IDLE    = 0;
  localparam int MODE_RINGING = 1;
  localparam int MODE_SNOOZED = 2;

  logic          clk_out = 1'b0;
  logic          reset = 1'b0;
  logic [CW-1:0] ch_sel = '0;
  logic          en_minutes = 1'b0;
  logic          en_hours = 1'b0;
  logic          up_down = 1'b1;
  logic          arm_toggle = 1'b0;
  logic [5:0]    cur_minutes = '0;
  logic [4:0]    cur_hours = '0;
  logic          minute_tick = 1'b0;
  logic          stop = 1'b0;
  logic          snooze = 1'b0;
  logic [3:0]    minutes_units;
  logic [2:0]    minutes_tens;
  logic [3:0]    hours_units;
  logic [1:0]    hours_tens;
  logic [N-1:0]  armed;
  logic          ring;
  logic [CW-1:0] ring_ch;

  always #5 clk_out = ~clk_out;

  multi_alarm_unit #(
    .N_ALARMS    (N),
    .SNOOZE_MIN  (SNZ),
    .RING_TIMEOUT(RTO)
  ) dut (
    .clk_out      (clk_out),
    .reset        (reset),
    .ch_sel       (ch_sel),
    .en_minutes   (en_minutes),
    .en_hours     (en_hours),
    .up_down      (up_down),
    .arm_toggle   (arm_toggle),
    .cur_minutes  (cur_minutes),
    .cur_hours    (cur_hours),
    .minute_tick  (minute_tick),
    .stop         (stop),
    .snooze       (snooze),
    .minutes_units(minutes_units),
    .minutes_tens (minutes_tens),
    .hours_units  (hours_units),
    .hours_tens   (hours_tens),
    .armed        (armed),
    .ring         (ring),
    .ring_ch      (ring_ch)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: plain alarm-clock behaviour
  int m_min [N];
  int m_hr  [N];
  bit m_armed [N];
  int m_mode;
  int m_ring_ch;
  int m_ring_minutes;
  int m_snooze_left;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  function automatic void model_clock();
    int sel;
    int hit;
    bit valid;
    bit snz;
    bit kill;
    sel   = int'(ch_sel);
    valid = (sel < N);
    hit   = -1;
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        m_min[i] = 0; m_hr[i] = 0; m_armed[i] = 0;
      end
      m_mode = MODE_IDLE; m_ring_ch = 0; m_ring_minutes = 0; m_snooze_left = 0;
      return;
    end
    for (int i = N - 1; i >= 0; i--)
      if (m_armed[i] && m_min[i] == int'(cur_minutes) && m_hr[i] == int'(cur_hours)) hit = i;
    snz  = SNOOZE_ON && snooze;
    kill = stop || (valid && arm_toggle && sel == m_ring_ch);
    case (m_mode)
      MODE_IDLE:
        if (minute_tick && hit >= 0 && !stop && !snz) begin
          m_mode = MODE_RINGING; m_ring_ch = hit; m_ring_minutes = 0;
        end
      MODE_RINGING:
        if (kill) m_mode = MODE_IDLE;
        else if (snz) begin
          m_mode = MODE_SNOOZED; m_snooze_left = SNZ;
        end else if (minute_tick) begin
          m_ring_minutes++;
          if (m_ring_minutes >= RTO) m_mode = MODE_IDLE;
        end
      default:
        if (kill) m_mode = MODE_IDLE;
        else if (snz) m_snooze_left = SNZ;
        else if (minute_tick) begin
          m_snooze_left--;
          if (m_snooze_left == 0) begin
            m_mode = MODE_RINGING; m_ring_minutes = 0;
          end
        end
    endcase
    if (valid) begin
      if (en_minutes) m_min[sel] = (m_min[sel] + (up_down ? 1 : 59)) % 60;
      if (en_hours)   m_hr[sel]  = (m_hr[sel] + (up_down ? 1 : 23)) % 24;
      if (arm_toggle) m_armed[sel] = !m_armed[sel];
    end
  endfunction

  task automatic check_model(input string tag);
    int sel;
    logic [N-1:0] exp_armed;
    int em, eh;
    sel = int'(ch_sel);
    em  = (sel < N) ? m_min[sel] : 0;
    eh  = (sel < N) ? m_hr[sel] : 0;
    for (int i = 0; i < N; i++) exp_armed[i] = m_armed[i];
    check({tag, ".mu"}, 32'(minutes_units), em % 10);
    check({tag, ".mt"}, 32'(minutes_tens), em / 10);
    check({tag, ".hu"}, 32'(hours_units), eh % 10);
    check({tag, ".ht"}, 32'(hours_tens), eh / 10);
    check({tag, ".armed"}, 32'(armed), 32'(exp_armed));
    check({tag, ".ring"}, 32'(ring), (m_mode == MODE_RINGING) ? 1 : 0);
    check({tag, ".ring_ch"}, 32'(ring_ch), m_ring_ch);
  endtask

  task automatic cycle();
    model_clock();
    @(posedge clk_out);
    #1;
    check_model("cyc");
  endtask

  task automatic tick();
    minute_tick = 1'b1;
    cycle();
    minute_tick = 1'b0;
  endtask

  task automatic toggle_arm(input int ch);
    ch_sel = CW'(ch);
    arm_toggle = 1'b1;
    cycle();
    arm_toggle = 1'b0;
  endtask

  task automatic set_time(input int ch, input int h, input int m);
    ch_sel = CW'(ch);
    up_down = 1'b1;
    en_hours = 1'b1;
    repeat ((h - m_hr[ch] + 24) % 24) cycle();
    en_hours = 1'b0;
    en_minutes = 1'b1;
    repeat ((m - m_min[ch] + 60) % 60) cycle();
    en_minutes = 1'b0;
  endtask

  initial begin
    int k;
    // Reset
    reset = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
    check("rst_ring", 32'(ring), 0);
    check("rst_armed", 32'(armed), 0);
    check("rst_ring_ch", 32'(ring_ch), 0);

    // Hours up 25 from 00 -> 01, then minutes down 00 -> 59
    ch_sel = 2'd2; up_down = 1'b1; en_hours = 1'b1;
    repeat (25) cycle();
    en_hours = 1'b0;
    check("hr25_units", 32'(hours_units), 1);
    check("hr25_tens", 32'(hours_tens), 0);
    up_down = 1'b0; en_minutes = 1'b1;
    cycle();
    en_minutes = 1'b0;
    check("mdown_units", 32'(minutes_units), 9);
    check("mdown_tens", 32'(minutes_tens), 5);
    check("mdown_hr", 32'(hours_units), 1);
    // 59 + 1 wraps to 00 without carrying into hours
    up_down = 1'b1; en_minutes = 1'b1;
    cycle();
    en_minutes = 1'b0;
    check("mwrap_min", 32'(minutes_units), 0);
    check("mwrap_hr", 32'(hours_units), 1);
    // Both fields down together: 01:00 -> 00:59
    up_down = 1'b0; en_minutes = 1'b1; en_hours = 1'b1;
    cycle();
    en_minutes = 1'b0; en_hours = 1'b0;
    check("both_min", 32'(minutes_tens), 5);
    check("both_hr", 32'(hours_units), 0);

    // Two channels armed at 07:30, lowest index rings
    set_time(1, 7, 30);
    set_time(3, 7, 30);
    toggle_arm(1);
    toggle_arm(3);
    check("armed13", 32'(armed), 32'b1010);
    cur_hours = 5'd7; cur_minutes = 6'd30;
    cycle();
    check("pre_tick_ring", 32'(ring), 0);
    tick();
    check("trig_ring", 32'(ring), 1);
    check("trig_ch", 32'(ring_ch), 1);
    cur_hours = 5'd8; cur_minutes = 6'd0;

    // Auto-off after RING_TIMEOUT ticks
    for (int i = 1; i <= RTO; i++) begin
      tick();
      check("timeout_ring", 32'(ring), (i < RTO) ? 1 : 0);
      cycle();
    end

    // Snooze behaviour
    cur_hours = 5'd7; cur_minutes = 6'd30;
    tick();
    check("retrig_ring", 32'(ring), 1);
    cur_hours = 5'd8; cur_minutes = 6'd0;
    snooze = 1'b1;
    cycle();
    snooze = 1'b0;
    if (SNOOZE_ON) begin
      check("snz_ring_off", 32'(ring), 0);
      for (int i = 1; i <= SNZ; i++) begin
        tick();
        check("snz_count", 32'(ring), (i == SNZ) ? 1 : 0);
      end
    end else begin
      check("snz_ignored", 32'(ring), 1);
    end
    stop = 1'b1; snooze = 1'b1;
    cycle();
    stop = 1'b0; snooze = 1'b0;
    check("stop_wins", 32'(ring), 0);
    repeat (SNZ) tick();
    check("idle_after_stop", 32'(ring), 0);

    // Disarm ringing channel 0
    set_time(0, 9, 15);
    toggle_arm(0);
    cur_hours = 5'd9; cur_minutes = 6'd15;
    tick();
    check("ch0_ring", 32'(ring), 1);
    check("ch0_ring_ch", 32'(ring_ch), 0);
    cur_hours = 5'd8; cur_minutes = 6'd0;
    toggle_arm(0);
    check("disarm_ring", 32'(ring), 0);
    check("disarm_bit", 32'(armed[0]), 0);

    // Reset while ringing with edited times
    cur_hours = 5'd7; cur_minutes = 6'd30;
    tick();
    check("pre_rst_ring", 32'(ring), 1);
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    check("rst2_ring", 32'(ring), 0);
    check("rst2_armed", 32'(armed), 0);
    for (int s = 0; s < N; s++) begin
      ch_sel = CW'(s);
      #1;
      check("rst2_digits", {minutes_units, minutes_tens, hours_units, hours_tens}, 0);
    end

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      ch_sel      = CW'($urandom_range(0, N - 1));
      en_minutes  = ($urandom_range(0, 4) == 0);
      en_hours    = ($urandom_range(0, 5) == 0);
      up_down     = 1'($urandom_range(0, 1));
      arm_toggle  = ($urandom_range(0, 6) == 0);
      minute_tick = ($urandom_range(0, 2) == 0);
      stop        = ($urandom_range(0, 24) == 0);
      snooze      = ($urandom_range(0, 11) == 0);
      reset       = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 1) == 1) begin
        k = int'($urandom_range(0, N - 1));
        cur_minutes = 6'(m_min[k]);
        cur_hours   = 5'(m_hr[k]);
      end else begin
        cur_minutes = 6'($urandom_range(0, 59));
        cur_hours   = 5'($urandom_range(0, 23));
      end
      cycle();
    end
    reset = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_alarm_unit.md
MULTI_ALARM_UNIT -- requirements
Module: multi_alarm_unit

Interface
REQ-001 SHALL have parameters, one per line:
- N_ALARMS, 4, number of alarm channels (1..16).
- SNOOZE_MIN, 5, snooze length in minute ticks (1..59).
- RING_TIMEOUT, 10, ring auto-off length in minute ticks (1..59).
REQ-002 SHALL have one clock and a synchronous, active-low reset. Ports, one per line, with CW = max(1, clog2(N_ALARMS)):
- clk_out  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- ch_sel  in  CW  channel selected for edit and display.
- en_minutes  in  1  step the selected channel's minutes once per clock while high.
- en_hours  in  1  step the selected channel's hours once per clock while high.
- up_down  in  1  1 = increment, 0 = decrement.
- arm_toggle  in  1  one-cycle pulse; toggles the armed bit of the selected channel.
- cur_minutes  in  6  current time minutes, binary 0..59.
- cur_hours  in  5  current time hours, binary 0..23.
- minute_tick  in  1  one-cycle pulse when the current time changes minute.
- stop  in  1  one-cycle pulse; silence the alarm.
- snooze  in  1  one-cycle pulse; snooze the alarm.
- minutes_units  out  4  selected channel minutes mod 10.
- minutes_tens  out  3  selected channel minutes / 10.
- hours_units  out  4  selected channel hours mod 10.
- hours_tens  out  2  selected channel hours / 10.
- armed  out  N_ALARMS  armed bit per channel.
- ring  out  1  high while the FSM is in RINGING.
- ring_ch  out  CW  index of the channel that triggered the ring.

Function
REQ-003 Each channel SHALL hold a binary minutes register (0..59) and a binary hours register (0..23), each wrapping in both directions (59+1 -> 0, 0-1 -> 59, 23+1 -> 0, 0-1 -> 23).
REQ-004 A minutes wrap SHALL NOT carry into hours; en_minutes and en_hours both high SHALL update both fields in the same cycle.
REQ-005 Digit outputs SHALL be combinational from the selected channel (zero latency). For ch_sel >= N_ALARMS, digit outputs SHALL be 0 and edit/arm inputs SHALL be ignored.
REQ-006 The FSM SHALL have three states: IDLE, RINGING, SNOOZED. Outputs: ring = (state == RINGING); ring_ch SHALL hold its value until the next trigger.
REQ-007 In IDLE, on minute_tick, if any armed channel time equals cur_hours:cur_minutes, the FSM SHALL enter RINGING. ring_ch SHALL be the lowest-index matching channel, and ring SHALL rise one cycle after the tick. The ring-minute counter SHALL clear to 0.
REQ-008 In RINGING, each minute_tick SHALL increment the ring-minute counter; when the counter reaches RING_TIMEOUT the FSM SHALL go to IDLE.
REQ-009 In RINGING, stop SHALL go to IDLE; snooze SHALL go to SNOOZED and load the snooze counter with SNOOZE_MIN.
REQ-010 In SNOOZED, each minute_tick SHALL decrement the snooze counter. The tick that brings it to 0 SHALL go to RINGING, with the ring-minute counter cleared. stop SHALL go to IDLE.
REQ-011 stop and snooze in the same cycle: stop SHALL win.
REQ-012 stop or snooze in the same cycle as a state-changing minute_tick: stop/snooze SHALL win.
REQ-013 Disarming channel ring_ch while in RINGING or SNOOZED SHALL go to IDLE in the same clock.
REQ-014 Matches while not IDLE SHALL be discarded, not queued.
REQ-015 Editing any channel time SHALL NOT alter the current FSM state.

Reset
REQ-016 While reset = 0 at a clk_out edge, all of the following SHALL be set, and reset SHALL dominate every other input:
- every channel time = 00:00;
- armed = 0;
- state = IDLE;
- ring = 0, ring_ch = 0;
- both internal counters = 0.
REQ-017 Reset asserted mid-ring SHALL drop ring on the next edge.

Configuration
REQ-018 Macro MULTI_ALARM_SNOOZE_EN defined: SNOOZED state and snooze input behave per REQ-009/010.
REQ-019 Macro MULTI_ALARM_SNOOZE_EN undefined: snooze port SHALL be present but ignored, and SNOOZED SHALL be unreachable. A ring then ends only via stop, timeout or disarm.

Verification
REQ-020 Directed scenarios the bench SHALL cover:
- Select ch 2; en_hours up 25 clocks from 00 -> displays hours 01; en_minutes down 1 clock from 00 -> minutes 59, hours still 01.
- Arm ch1 and ch3 both at 07:30; cur = 07:30, minute_tick -> ring=1 next cycle, ring_ch=1.
- Ringing, then 10 minute_ticks with no input -> ring=0 after the 10th tick (RING_TIMEOUT=10).
- With MULTI_ALARM_SNOOZE_EN: snooze, then 5 ticks -> ring re-asserts after the 5th tick. stop and snooze in the same cycle -> IDLE.
- Ringing on ch0: arm_toggle with ch_sel=0 -> ring=0 next cycle, armed[0]=0.
- reset=0 while ringing with edited times -> next edge: ring=0, armed=0, all digits 0.
